btb_assoc_array: RTL and testbench

//  Set-associative branch target buffer storage for the lc3b fetch stage. Holds per-way
//  tag/valid/target, tree-PLRU replacement, registered lookup, and a one-set-per-cycle

---
 rtl/btb_assoc_array.sv | 154 +++++++++++++++
 tb/tb_btb_assoc_array.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/btb_assoc_array.sv
// btb_assoc_array: set-associative BTB storage with tree-PLRU, registered lookup and flush sweep (optional BTB_BYPASS_EN forwards same-cycle updates to lookups)
module btb_assoc_array #(
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int TAG_W  = 9,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lkp_valid,
    input  logic [$clog2(SETS)-1:0]  lkp_index,
    input  logic [TAG_W-1:0]         lkp_tag,
    output logic                     lkp_rsp_valid,
    output logic                     lkp_hit,
    output logic [1:0]               lkp_way,
    output logic [DATA_W-1:0]        lkp_target,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [$clog2(SETS)-1:0]  upd_index,
    input  logic [TAG_W-1:0]         upd_tag,
    input  logic [DATA_W-1:0]        upd_target,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     flush_done
);
    localparam int IDX_W = $clog2(SETS);
    localparam logic IDLE  = 1'b0;
    localparam logic FLUSH = 1'b1;

    logic                 state;
    logic [IDX_W-1:0]     ptr;
    logic [WAYS-1:0]      valid_q [SETS];
    logic [2:0]           plru_q  [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]    tgt_q   [SETS][WAYS];
    logic                 lk_hit, up_hit, inv_found, upd_acc, lk_ok, byp;
    logic [1:0]           lk_way, up_hit_way, inv_way, up_way;
    logic [DATA_W-1:0]    lk_tgt;
    logic [WAYS-1:0]      up_mask;

    // Tree bits: [0] root (0 = victim in ways 0/1), [1] victim within 0/1, [2] victim within 2/3
    function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n = p;
        if (WAYS == 2) n[0] = ~w[0];
        else if (WAYS == 4) begin
            n[0] = ~w[1];
            if (w[1]) n[2] = ~w[0];
            else n[1] = ~w[0];
        end
        return n;
    endfunction

    function automatic logic [1:0] victim(input logic [2:0] p);
        return WAYS == 2 ? {1'b0, p[0]} : WAYS == 4 ? (p[0] ? {1'b1, p[2]} : {1'b0, p[1]}) : 2'd0;
    endfunction

    assign upd_ready  = state == IDLE;
    assign flush_busy = state == FLUSH;
    assign upd_acc    = upd_valid && upd_ready;
    assign lk_ok      = lkp_valid && lk_hit && state == IDLE;
    assign up_mask    = WAYS'(1) << up_way;
`ifdef BTB_BYPASS_EN
    assign byp = lkp_valid && upd_acc && lkp_index == upd_index && lkp_tag == upd_tag;
`else
    assign byp = 1'b0;
`endif

    // Tag compare for the lookup set, and way selection (dedup, lowest invalid, PLRU victim) for the update set
    always_comb begin
        lk_hit     = 1'b0;
        lk_way     = 2'd0;
        lk_tgt     = '0;
        up_hit     = 1'b0;
        up_hit_way = 2'd0;
        inv_found  = 1'b0;
        inv_way    = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lkp_index][w] && tag_q[lkp_index][w] == lkp_tag) begin
                lk_hit = 1'b1;
                lk_way = 2'(w);
                lk_tgt = tgt_q[lkp_index][w];
            end
            if (valid_q[upd_index][w] && tag_q[upd_index][w] == upd_tag) begin
                up_hit     = 1'b1;
                up_hit_way = 2'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_index][w]) begin
                inv_found = 1'b1;
                inv_way   = 2'(w);
            end
        end
        up_way = up_hit ? up_hit_way : inv_found ? inv_way : victim(plru_q[upd_index]);
    end

    // Flush sequencer plus valid/PLRU state; lookup touch precedes update touch when both hit one set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            flush_done <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (state == FLUSH) begin
            valid_q[ptr] <= '0;
            plru_q[ptr]  <= '0;
            ptr          <= ptr + 1'b1;
            state        <= ptr == IDX_W'(SETS - 1) ? IDLE : FLUSH;
            flush_done   <= ptr == IDX_W'(SETS - 1);
        end else begin
            flush_done <= 1'b0;
            if (flush_req) begin
                state <= FLUSH;
                ptr   <= '0;
            end
            if (upd_acc) valid_q[upd_index] <= valid_q[upd_index] | up_mask;
            if (lk_ok && upd_acc && lkp_index == upd_index)
                plru_q[upd_index] <= touch(touch(plru_q[upd_index], lk_way), up_way);
            else begin
                if (lk_ok) plru_q[lkp_index] <= touch(plru_q[lkp_index], lk_way);
                if (upd_acc) plru_q[upd_index] <= touch(plru_q[upd_index], up_way);
            end
        end
    end

    // Tag/target RAM, written only for accepted updates and never reset
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (upd_acc && up_way == 2'(w)) begin
                tag_q[upd_index][w] <= upd_tag;
                tgt_q[upd_index][w] <= upd_target;
            end
        end
    end

    // Registered lookup response; misses and flush-time lookups return zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkp_rsp_valid <= 1'b0;
            lkp_hit       <= 1'b0;
            lkp_way       <= 2'd0;
            lkp_target    <= '0;
        end else begin
            lkp_rsp_valid <= lkp_valid;
            lkp_hit       <= byp || lk_ok;
            lkp_way       <= byp ? up_way : lk_ok ? lk_way : 2'd0;
            lkp_target    <= byp ? upd_target : lk_ok ? lk_tgt : '0;
        end
    end
endmodule

// File: tb/tb_btb_assoc_array.sv
// tb_btb_assoc_array: scoreboard bench for btb_assoc_array against an LRU-timestamp reference model
module tb_btb_assoc_array;
    localparam int SETS = 8, WAYS = 2, TAG_W = 9, DATA_W = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic lkp_valid = 0, upd_valid = 0, flush_req = 0;
    logic [2:0] lkp_index = 0, upd_index = 0;
    logic [TAG_W-1:0] lkp_tag = 0, upd_tag = 0;
    logic [DATA_W-1:0] upd_target = 0, lkp_target;
    logic lkp_rsp_valid, lkp_hit, upd_ready, flush_busy, flush_done;
    logic [1:0] lkp_way;

    always #5 clk = ~clk;

    btb_assoc_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .lkp_valid(lkp_valid), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
        .lkp_rsp_valid(lkp_rsp_valid), .lkp_hit(lkp_hit), .lkp_way(lkp_way), .lkp_target(lkp_target),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_tag(upd_tag),
        .upd_target(upd_target), .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
    );

    typedef struct {bit hit; int way; int tgt;} rsp_t;
    rsp_t q[$];

    bit mv[SETS][WAYS];
    int mt[SETS][WAYS], md[SETS][WAYS], ts[SETS][WAYS];
    int tick = 0, m_ptr = 0, tests = 0, fails = 0;
    bit m_fl = 0, m_done = 0, prev_lv = 0, chk_en = 0;
    bit cur_busy = 0, cur_ready = 1, cur_done = 0, cur_rsp = 0;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0;
                ts[s][w] = 0;
            end
        m_fl = 0; m_done = 0; m_ptr = 0; prev_lv = 0;
        cur_busy = 0; cur_ready = 1; cur_done = 0; cur_rsp = 0;
    endtask

    function automatic int pick_way(input int s, input int t);
        int best;
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) return w;
        for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
        best = 0;
        for (int w = 1; w < WAYS; w++) if (ts[s][w] < ts[s][best]) best = w;
        return best;
    endfunction

    // Monitor: per-cycle status checks and scoreboard pops on each response
    always @(negedge clk) begin
        rsp_t e;
        if (chk_en) begin
            chk("flush_busy", int'(flush_busy), int'(cur_busy));
            chk("upd_ready", int'(upd_ready), int'(cur_ready));
            chk("flush_done", int'(flush_done), int'(cur_done));
            chk("rsp_valid", int'(lkp_rsp_valid), int'(cur_rsp));
            if (lkp_rsp_valid) begin
                if (q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("lkp_hit", int'(lkp_hit), int'(e.hit));
                    chk("lkp_way", int'(lkp_way), e.way);
                    chk("lkp_target", int'(lkp_target), e.tgt);
                end
            end
        end
    end

    task automatic cyc(input bit lv, input int li, input int lt, input bit uv, input int ui,
                       input int ut, input int ug, input bit fr);
        rsp_t r;
        bit acc, lh;
        int lw, uw;
        @(posedge clk);
        #1;
        cur_busy = m_fl; cur_ready = !m_fl; cur_done = m_done; cur_rsp = prev_lv; prev_lv = lv;
        lkp_valid = lv; lkp_index = 3'(li); lkp_tag = 9'(lt);
        upd_valid = uv; upd_index = 3'(ui); upd_tag = 9'(ut); upd_target = 16'(ug); flush_req = fr;
        acc = uv && !m_fl;
        lh = 0; lw = 0; uw = 0;
        r.hit = 0; r.way = 0; r.tgt = 0;
        if (lv && !m_fl)
            for (int w = 0; w < WAYS; w++)
                if (mv[li][w] && mt[li][w] == lt) begin
                    lh = 1; lw = w; r.hit = 1; r.way = w; r.tgt = md[li][w];
                end
        if (acc) uw = pick_way(ui, ut);
`ifdef BTB_BYPASS_EN
        if (lv && acc && li == ui && lt == ut) begin
            r.hit = 1; r.way = uw; r.tgt = ug;
        end
`endif
        if (lv) q.push_back(r);
        if (lh) begin tick++; ts[li][lw] = tick; end
        if (acc) begin
            tick++;
            mv[ui][uw] = 1; mt[ui][uw] = ut; md[ui][uw] = ug; ts[ui][uw] = tick;
        end
        if (m_fl) begin
            for (int w = 0; w < WAYS; w++) begin mv[m_ptr][w] = 0; ts[m_ptr][w] = 0; end
            m_done = m_ptr == SETS - 1;
            m_fl = m_ptr != SETS - 1;
            m_ptr++;
        end else begin
            m_done = 0;
            if (fr) begin m_fl = 1; m_ptr = 0; end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_rsp_valid", int'(lkp_rsp_valid), 0);
        chk("rst_hit", int'(lkp_hit), 0);
        chk("rst_target", int'(lkp_target), 0);
        chk("rst_ready", int'(upd_ready), 1);
        chk("rst_busy", int'(flush_busy), 0);
        chk("rst_done", int'(flush_done), 0);
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        cyc(1, 3, 'h05, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 'h05, 'h1234, 0);
        cyc(1, 3, 'h05, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 'h0A, 'h1111, 0);
        cyc(0, 0, 0, 1, 1, 'h0B, 'h2222, 0);
        cyc(1, 1, 'h0A, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 'h0C, 'h3333, 0);
        cyc(1, 1, 'h0B, 0, 0, 0, 0, 0);
        cyc(1, 1, 'h0C, 1, 1, 'h0A, 'h00FF, 0);
        cyc(1, 1, 'h0A, 0, 0, 0, 0, 0);
        for (int s = 0; s < SETS; s++) cyc(0, 0, 0, 1, s, 'h40 + s, 'h5000 + s, 0);
        cyc(1, 2, 'h42, 0, 0, 0, 0, 1);
        cyc(1, 2, 'h42, 1, 4, 'h99, 'h7777, 1);
        idle(SETS);
        for (int s = 0; s < SETS; s++) cyc(1, s, 'h40 + s, 0, 0, 0, 0, 0);
        cyc(1, 5, 'h77, 1, 5, 'h77, 'hBEEF, 0);
        cyc(1, 5, 'h77, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        @(posedge clk);
        #2;
        chk_en = 0;
        rst_n = 0;
        lkp_valid = 0; upd_valid = 0; flush_req = 0;
        #1;
        chk("abort_busy", int'(flush_busy), 0);
        chk("abort_ready", int'(upd_ready), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        cyc(1, 5, 'h77, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++)
            cyc($urandom % 2, $urandom % 4, $urandom % 4, $urandom % 2, $urandom % 4,
                $urandom % 4, $urandom % 65536, ($urandom % 60) == 0);
        idle(SETS + 3);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
